// File: rtl/d_ff_shift_reg_pkg.sv
// Shared definitions for the d_ff_shift_reg register bank.
//   - MODE_* : encodings of the 2-bit Mode operation select
//   - state_t: auto-shift engine states (idle / shifting)
package d_ff_pkg;

  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_SHR  = 2'b01;
  localparam logic [1:0] MODE_SHL  = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

endpackage

// File: rtl/d_ff_shift_reg_cell.sv
// d_ff_cell: one storage bit of the register bank.
// Ports:
//   clock  - clock; active edge chosen by NEGEDGE (1 = falling, 0 = rising)
//   reset  - synchronous active-high reset, loads RESET_VAL
//   enable - clock enable; bit holds when low
//   d      - next value
//   q      - stored bit
//   qbar   - registered complement of q
module d_ff_cell #(
  parameter bit   NEGEDGE   = 1'b1,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clock,
  input  logic reset,
  input  logic enable,
  input  logic d,
  output logic q,
  output logic qbar
);

  // Only one of the two branches is elaborated, so there is never any logic
  // on the inactive edge.
  generate
    if (NEGEDGE) begin : g_neg
      // NOTE: sequential state uses non-blocking (<=) so every flop samples
      // the values from before the edge, independent of statement order.
      always_ff @(negedge clock) begin
        if (reset) begin
          q    <= RESET_VAL;
          qbar <= ~RESET_VAL;
        end else if (enable) begin
          q    <= d;
          qbar <= ~d;
        end
      end
    end else begin : g_pos
      always_ff @(posedge clock) begin
        if (reset) begin
          q    <= RESET_VAL;
          qbar <= ~RESET_VAL;
        end else if (enable) begin
          q    <= d;
          qbar <= ~d;
        end
      end
    end
  endgenerate

endmodule

// File: rtl/d_ff_shift_reg.sv
// d_ff_shift_reg: WIDTH-bit universal shift register with an auto-shift
// serialiser.
// Ports:
//   Clock       - clock; active edge selected by NEGEDGE
//   Reset       - synchronous active-high reset (Enable don't-care)
//   Enable      - clock enable; low freezes Q, counter and FSM
//   Mode        - 00 hold, 01 shift right, 10 shift left, 11 parallel load
//   D           - parallel load data
//   SerialInR   - bit entering the MSB on a right shift
//   SerialInL   - bit entering the LSB on a left shift
//   Start       - begin an auto right-shift of Count bits (from idle only)
//   Count       - number of bits to auto-shift, clamped to WIDTH
//   Q / Qbar    - register contents and its registered complement
//   SerialOutR  - Q[0]
//   SerialOutL  - Q[WIDTH-1]
//   Busy        - auto-shift in progress
//   Done        - one-edge pulse when an auto-shift completes
module d_ff_shift_reg
  import d_ff_pkg::*;
#(
  parameter int                 WIDTH     = 8,
  parameter bit                 NEGEDGE   = 1'b1,
  parameter logic [WIDTH-1:0]   RESET_VAL = '0,
  parameter bit                 ROTATE    = 1'b0,
  localparam int                CW        = $clog2(WIDTH + 1)
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Enable,
  input  logic [1:0]       Mode,
  input  logic [WIDTH-1:0] D,
  input  logic             SerialInR,
  input  logic             SerialInL,
  input  logic             Start,
  input  logic [CW-1:0]    Count,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Qbar,
  output logic             SerialOutR,
  output logic             SerialOutL,
  output logic             Busy,
  output logic             Done
);

  logic [WIDTH-1:0] q_d;
  state_t           state_q, state_d;
  logic [CW-1:0]    rem_q, rem_d;
  logic             done_q, done_d;

  logic [CW-1:0]    count_clamped;
  logic             shr_in, shl_in;
  logic [WIDTH-1:0] shr_val, shl_val;

  assign count_clamped = (Count > CW'(WIDTH)) ? CW'(WIDTH) : Count;

  // Rotation feeds the end bit back in and ignores the serial inputs.
  assign shr_in  = ROTATE ? Q[0]       : SerialInR;
  assign shl_in  = ROTATE ? Q[WIDTH-1] : SerialInL;
  assign shr_val = {shr_in, Q[WIDTH-1:1]};
  assign shl_val = {Q[WIDTH-2:0], shl_in};

  always_comb begin
    // NOTE: every signal gets a default before any branch; without it a
    // missed path would hold its old value and infer a latch.
    q_d     = Q;
    state_d = state_q;
    rem_d   = rem_q;
    done_d  = 1'b0;  // Done lasts one active edge, even while Enable is low

    if (Enable) begin
      case (state_q)
        ST_IDLE: begin
          if (Start) begin
            if (count_clamped == '0) begin
              done_d = 1'b1;
            end else begin
              // The start edge performs the first shift itself.
              q_d   = shr_val;
              rem_d = count_clamped - CW'(1);
              if (count_clamped == CW'(1)) done_d  = 1'b1;
              else                         state_d = ST_SHIFT;
            end
          end else begin
            case (Mode)
              MODE_SHR:  q_d = shr_val;
              MODE_SHL:  q_d = shl_val;
              MODE_LOAD: q_d = D;
              default:   q_d = Q;
            endcase
          end
        end
        ST_SHIFT: begin
          // Start and Mode are ignored here.
          q_d   = shr_val;
          rem_d = rem_q - CW'(1);
          if (rem_q == CW'(1)) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  generate
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      d_ff_cell #(
        .NEGEDGE   (NEGEDGE),
        .RESET_VAL (RESET_VAL[i])
      ) u_cell (
        .clock  (Clock),
        .reset  (Reset),
        .enable (Enable),
        .d      (q_d[i]),
        .q      (Q[i]),
        .qbar   (Qbar[i])
      );
    end

    if (NEGEDGE) begin : g_ctl_neg
      always_ff @(negedge Clock) begin
        if (Reset) begin
          state_q <= ST_IDLE;
          rem_q   <= '0;
          done_q  <= 1'b0;
        end else begin
          state_q <= state_d;
          rem_q   <= rem_d;
          done_q  <= done_d;
        end
      end
    end else begin : g_ctl_pos
      always_ff @(posedge Clock) begin
        if (Reset) begin
          state_q <= ST_IDLE;
          rem_q   <= '0;
          done_q  <= 1'b0;
        end else begin
          state_q <= state_d;
          rem_q   <= rem_d;
          done_q  <= done_d;
        end
      end
    end
  endgenerate

  assign SerialOutR = Q[0];
  assign SerialOutL = Q[WIDTH-1];
  assign Busy       = (state_q == ST_SHIFT);
  assign Done       = done_q;

endmodule

// File: tb/tb_d_ff_shift_reg.sv
// Scoreboard bench: the driver applies one directed vector per clock and
// pushes the hand-computed response; the monitor pops one entry per clock on
// the rising edge (away from the active falling edge) and compares.
module tb_d_ff_shift_reg;
  import d_ff_pkg::*;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, en, sir, sil, start;
  logic [1:0] mode;
  logic [7:0] d;
  logic [3:0] cnt;

  logic [7:0] q, qb, q_r, qb_r;
  logic       sor, sol, busy, done;
  logic       sor_r, sol_r, busy_r, done_r;

  d_ff_shift_reg #(.WIDTH(8), .NEGEDGE(1'b1), .RESET_VAL(8'h00), .ROTATE(1'b0)) dut (
    .Clock(clk), .Reset(rst), .Enable(en), .Mode(mode), .D(d),
    .SerialInR(sir), .SerialInL(sil), .Start(start), .Count(cnt),
    .Q(q), .Qbar(qb), .SerialOutR(sor), .SerialOutL(sol), .Busy(busy), .Done(done)
  );

  d_ff_shift_reg #(.WIDTH(8), .NEGEDGE(1'b1), .RESET_VAL(8'h00), .ROTATE(1'b1)) dut_rot (
    .Clock(clk), .Reset(rst), .Enable(en), .Mode(mode), .D(d),
    .SerialInR(sir), .SerialInL(sil), .Start(start), .Count(cnt),
    .Q(q_r), .Qbar(qb_r), .SerialOutR(sor_r), .SerialOutL(sol_r), .Busy(busy_r), .Done(done_r)
  );

  typedef struct {
    string      name;
    logic       rot;
    logic [7:0] q;
    logic       busy;
    logic       done;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: one expected entry per clock, compared mid-cycle.
  always @(posedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      if (!e.rot) begin
        check({e.name, ".q"},    q,           e.q);
        check({e.name, ".qbar"}, qb,          ~e.q);
        check({e.name, ".sor"},  {7'd0, sor}, {7'd0, e.q[0]});
        check({e.name, ".sol"},  {7'd0, sol}, {7'd0, e.q[7]});
        check({e.name, ".busy"}, {7'd0, busy}, {7'd0, e.busy});
        check({e.name, ".done"}, {7'd0, done}, {7'd0, e.done});
      end else begin
        check({e.name, ".q"},    q_r,            e.q);
        check({e.name, ".qbar"}, qb_r,           ~e.q);
        check({e.name, ".busy"}, {7'd0, busy_r}, {7'd0, e.busy});
        check({e.name, ".done"}, {7'd0, done_r}, {7'd0, e.done});
      end
    end
  end

  // Apply one vector for the next falling edge and record its expected result.
  task automatic step(input string name, input logic rot,
                      input logic r, input logic e, input logic [1:0] m,
                      input logic [7:0] dv, input logic sr, input logic sl,
                      input logic st, input logic [3:0] c,
                      input logic [7:0] eq, input logic eb, input logic ed);
    exp_t x;
    @(posedge clk);
    #1;
    rst = r; en = e; mode = m; d = dv; sir = sr; sil = sl; start = st; cnt = c;
    x.name = name; x.rot = rot; x.q = eq; x.busy = eb; x.done = ed;
    exp_q.push_back(x);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; en = 1'b0; mode = MODE_HOLD; d = 8'h00;
    sir = 1'b0; sil = 1'b0; start = 1'b0; cnt = 4'd0;

    //    name          rot  rst  en  mode       d      sir sil st  cnt    q      b  d
    step("rst0",        0, 1,   1,  MODE_HOLD, 8'h00, 0,  0,  0,  4'd0,  8'h00, 0, 0);
    step("load_ff",     0, 0,   1,  MODE_LOAD, 8'hFF, 0,  0,  0,  4'd0,  8'hFF, 0, 0);
    step("rst",         0, 1,   0,  MODE_LOAD, 8'h12, 0,  0,  0,  4'd0,  8'h00, 0, 0);
    // LOAD present only across a rising edge must not change Q.
    @(negedge clk); #1; mode = MODE_LOAD; d = 8'h55;
    step("edge_sel",    0, 0,   1,  MODE_HOLD, 8'h55, 0,  0,  0,  4'd0,  8'h00, 0, 0);
    step("load_a5",     0, 0,   1,  MODE_LOAD, 8'hA5, 0,  0,  0,  4'd0,  8'hA5, 0, 0);
    step("shr",         0, 0,   1,  MODE_SHR,  8'h00, 1,  0,  0,  4'd0,  8'hD2, 0, 0);
    step("shl",         0, 0,   1,  MODE_SHL,  8'h00, 0,  0,  0,  4'd0,  8'hA4, 0, 0);
    step("hold",        0, 0,   1,  MODE_HOLD, 8'h00, 0,  0,  0,  4'd0,  8'hA4, 0, 0);
    step("en_low",      0, 0,   0,  MODE_LOAD, 8'h00, 0,  0,  0,  4'd0,  8'hA4, 0, 0);
    // Auto-shift of 3 with a 2-edge stall and ignored Mode/Start while busy.
    step("load_0f",     0, 0,   1,  MODE_LOAD, 8'h0F, 0,  0,  0,  4'd0,  8'h0F, 0, 0);
    step("start3",      0, 0,   1,  MODE_HOLD, 8'h00, 0,  0,  1,  4'd3,  8'h07, 1, 0);
    step("stall1",      0, 0,   0,  MODE_HOLD, 8'h00, 0,  0,  0,  4'd3,  8'h07, 1, 0);
    step("stall2",      0, 0,   0,  MODE_HOLD, 8'h00, 0,  0,  0,  4'd3,  8'h07, 1, 0);
    step("ign_busy",    0, 0,   1,  MODE_LOAD, 8'hFF, 0,  0,  1,  4'd1,  8'h03, 1, 0);
    step("last3",       0, 0,   1,  MODE_HOLD, 8'h00, 0,  0,  0,  4'd3,  8'h01, 0, 1);
    step("mode_after",  0, 0,   1,  MODE_LOAD, 8'h3C, 0,  0,  0,  4'd0,  8'h3C, 0, 0);
    // Count = 0 and Count = 1; Done clears even with Enable low.
    step("cnt0",        0, 0,   1,  MODE_HOLD, 8'h00, 0,  0,  1,  4'd0,  8'h3C, 0, 1);
    step("cnt0_clr",    0, 0,   0,  MODE_HOLD, 8'h00, 0,  0,  0,  4'd0,  8'h3C, 0, 0);
    step("cnt1",        0, 0,   1,  MODE_HOLD, 8'h00, 1,  0,  1,  4'd1,  8'h9E, 0, 1);
    step("cnt1_clr",    0, 0,   1,  MODE_HOLD, 8'h00, 0,  0,  0,  4'd0,  8'h9E, 0, 0);
    // Count = 15 clamps to 8; Start held high re-triggers after Done.
    step("load_ff2",    0, 0,   1,  MODE_LOAD, 8'hFF, 0,  0,  0,  4'd0,  8'hFF, 0, 0);
    step("clamp1",      0, 0,   1,  MODE_HOLD, 8'h00, 0,  0,  1,  4'd15, 8'h7F, 1, 0);
    step("clamp2",      0, 0,   1,  MODE_HOLD, 8'h00, 0,  0,  1,  4'd15, 8'h3F, 1, 0);
    step("clamp3",      0, 0,   1,  MODE_HOLD, 8'h00, 0,  0,  1,  4'd15, 8'h1F, 1, 0);
    step("clamp4",      0, 0,   1,  MODE_HOLD, 8'h00, 0,  0,  1,  4'd15, 8'h0F, 1, 0);
    step("clamp5",      0, 0,   1,  MODE_HOLD, 8'h00, 0,  0,  1,  4'd15, 8'h07, 1, 0);
    step("clamp6",      0, 0,   1,  MODE_HOLD, 8'h00, 0,  0,  1,  4'd15, 8'h03, 1, 0);
    step("clamp7",      0, 0,   1,  MODE_HOLD, 8'h00, 0,  0,  1,  4'd15, 8'h01, 1, 0);
    step("clamp8",      0, 0,   1,  MODE_HOLD, 8'h00, 0,  0,  1,  4'd15, 8'h00, 0, 1);
    step("retrigger",   0, 0,   1,  MODE_HOLD, 8'h00, 1,  0,  1,  4'd15, 8'h80, 1, 0);
    step("rst_mid",     0, 1,   1,  MODE_HOLD, 8'h00, 1,  0,  0,  4'd15, 8'h00, 0, 0);
    step("after_rst",   0, 0,   1,  MODE_HOLD, 8'h00, 1,  0,  0,  4'd0,  8'h00, 0, 0);
    // Rotating instance.
    step("rot_load",    1, 0,   1,  MODE_LOAD, 8'h81, 0,  0,  0,  4'd0,  8'h81, 0, 0);
    step("rot_shr",     1, 0,   1,  MODE_SHR,  8'h00, 0,  0,  0,  4'd0,  8'hC0, 0, 0);
    step("rot_load2",   1, 0,   1,  MODE_LOAD, 8'h81, 0,  0,  0,  4'd0,  8'h81, 0, 0);
    step("rot_shl1",    1, 0,   1,  MODE_SHL,  8'h00, 0,  0,  0,  4'd0,  8'h03, 0, 0);
    step("rot_shl2",    1, 0,   1,  MODE_SHL,  8'h00, 0,  0,  0,  4'd0,  8'h06, 0, 0);

    // Let the monitor drain the final entry, bounded to a few cycles.
    for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/d_ff_shift_reg.md
Name: d_ff_shift_reg

Overview:
- Parametrised successor to the single-bit negative-edge D flip-flop.
- A WIDTH-bit register bank with the following features:
  - selectable active clock edge
  - synchronous active-high reset
  - clock enable
  - four-mode universal operation: hold, shift right, shift left, parallel load
  - an auto-shift engine that serialises a programmed number of bits and flags completion
- Used as the storage/serialiser primitive for the later serial-link and counter experiments.

Parameters:
- WIDTH, 8, register width in bits; legal range 2 to 32.
- NEGEDGE, 1, active edge: 1 = falling edge of Clock, 0 = rising edge.
- RESET_VAL, 0, value loaded into Q on reset (WIDTH bits).
- ROTATE, 0, 1 = shifts wrap the end bit around and ignore the serial inputs; 0 = shifts take the serial inputs.

Ports:
- Clock  input  1  single clock; sampled on the edge selected by NEGEDGE.
- Reset  input  1  synchronous, active-high reset, sampled on the active edge.
- Enable  input  1  clock enable. When low, all state holds (Q, counter, FSM).
- Mode  input  2  operation select: 00 hold, 01 shift right, 10 shift left, 11 parallel load.
- D  input  WIDTH  parallel load data.
- SerialInR  input  1  bit entering at MSB on a right shift.
- SerialInL  input  1  bit entering at LSB on a left shift.
- Start  input  1  begin an auto right-shift of Count bits.
- Count  input  CW  number of bits to auto-shift, where CW = $clog2(WIDTH+1). Values above WIDTH are clamped to WIDTH.
- Q  output  WIDTH  register contents.
- Qbar  output  WIDTH  bitwise complement of Q, registered alongside Q.
- SerialOutR  output  1  Q[0], i.e. the bit leaving on a right shift (combinational from Q).
- SerialOutL  output  1  Q[WIDTH-1] (combinational from Q).
- Busy  output  1  high while the auto-shift is in progress.
- Done  output  1  one-active-edge pulse when the auto-shift completes.

Behaviour:
- Edge selection and reset
  - All state updates only on the active edge; no logic on the inactive edge.
  - Reset (with Enable don't-care): Q = RESET_VAL, Qbar = ~RESET_VAL, Busy = 0, Done = 0, remaining counter = 0, FSM = IDLE.
  - Reset mid auto-shift aborts it immediately; no Done pulse is produced.
- Priority (highest first): Reset, then Enable low, then the auto-shift FSM, then Mode.
- Mode operations (IDLE only, Enable = 1), each taking effect on the next active edge with latency 1:
  - Hold: Q unchanged.
  - Shift right: Q <= {SerialInR, Q[WIDTH-1:1]}.
  - Shift left: Q <= {Q[WIDTH-2:0], SerialInL}.
  - Parallel load: Q <= D.
  - With ROTATE = 1, shifts use Q[0] and Q[WIDTH-1] respectively in place of the serial inputs.
- Qbar is always the complement of the next Q value, written on the same edge. Q and ~Qbar never differ after any edge.
- FSM: IDLE and SHIFT.
  - IDLE, Start = 1, clamped Count = N > 0:
    - The same edge performs the first right shift and loads remaining = N-1.
    - Go to SHIFT, Busy = 1.
    - If N = 1, go straight back to IDLE with Done = 1.
  - IDLE, Start = 1, Count = 0: no shift, Done = 1 for one edge, stay IDLE.
  - SHIFT, each enabled edge:
    - Right shift (SerialInR or rotate), remaining decrements.
    - When remaining reaches 0 on this edge, return to IDLE, Busy = 0, Done = 1.
  - Total: exactly N shifts across N enabled edges; Busy is high for N-1 edges after the start edge; Done is asserted in the cycle after the last shift.
- Start and Mode while Busy are ignored. Mode is honoured again from the edge after Done.
- Enable low during SHIFT stalls the shifting and the counter. Busy stays 1; Done is not issued until the shifts finish.
- Done is cleared on the next active edge regardless of Enable.
- Start held high continuously re-triggers only from IDLE, i.e. on the edge after Done. Back-to-back transfers are therefore legal.

Decomposition:
- Shared package d_ff_pkg holds:
  - mode constants MODE_HOLD = 2'b00, MODE_SHR = 2'b01, MODE_SHL = 2'b10, MODE_LOAD = 2'b11
  - FSM state encoding ST_IDLE, ST_SHIFT
- One sub-module, d_ff_cell:
  - single-bit flop with NEGEDGE parameter, synchronous Reset, Enable, reset value
  - outputs Q and Qbar
  - instanced WIDTH times by generate.
- Next-state mux, counter and FSM live in the parent.

Test Plan:
- All scenarios use WIDTH = 8, NEGEDGE = 1, RESET_VAL = 0, ROTATE = 0; checks are on falling edges.
- Reset and edge check:
  - Drive Q = 8'hFF, then hold Reset for one falling edge. Expect Q = 8'h00, Qbar = 8'hFF, Busy = 0, Done = 0.
  - Changing D and Mode around rising edges alone leaves Q untouched.
- Mode operations:
  - Load D = 8'hA5 gives Q = 8'hA5 and Qbar = 8'h5A.
  - Shift right with SerialInR = 1 gives 8'hD2.
  - Shift left with SerialInL = 0 gives 8'hA4.
  - Hold keeps 8'hA4.
- Auto-shift:
  - Load 8'h0F, then Start with Count = 3 and SerialInR = 0.
  - Expect Busy high for 2 edges, Q = 8'h01 after the 3rd shift, Done high for exactly one edge.
  - SerialOutR sequence after each shift is 1, 1, 1.
- Stall and ignore:
  - During the same auto-shift, drop Enable for 2 edges. Q and the counter freeze and Done is delayed by 2 edges.
  - Mode = LOAD and Start asserted while Busy have no effect.
- Boundaries:
  - Count = 0 gives a Done pulse with Q unchanged.
  - Count = 15 clamps to 8, giving exactly 8 shifts.
  - Reset asserted during SHIFT returns IDLE on that edge with no Done.
- Rotate:
  - Rebuild with ROTATE = 1, load 8'h81, then shift right once to get 8'hC0.
  - Shift left twice from 8'h81 to get 8'h06.
